s2p_lane_arbiter: RTL and testbench

Round-robin controller that shares one serial-to-parallel converter among NREQ serial lanes. It grants the converter to one requesting lane at a time and steers that lane's serial bits into the converter. It captures the assembled word and hands it to a downstream consumer, tagged with the lane id, over a valid/ready handshake. It sits between the per-lane serial sources and the shared converter instance. It owns all sequencing of that converter: start pulse, bit steering, completion wait and timeout.

---
 rtl/s2p_lane_arbiter.sv | 163 ++++++++++++++++
 tb/tb_s2p_lane_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2p_lane_arbiter.sv
// Round-robin arbiter that time-shares one serial-to-parallel converter among NREQ lanes
// and delivers each assembled word, tagged with its lane id, over a valid/ready handshake.
module s2p_lane_arbiter #(
   parameter int NREQ    = 4,
   parameter int NBITS   = 8,
   parameter int TIMEOUT = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ-1:0]           ser_d,
   output logic [NREQ-1:0]           grant,
   output logic [$clog2(NBITS)-1:0]  bit_idx,
   output logic                      conv_start,
   output logic                      conv_d,
   input  logic                      conv_end,
   input  logic [NBITS-1:0]          conv_data,
   output logic                      out_valid,
   output logic [NBITS-1:0]          out_data,
   output logic [$clog2(NREQ)-1:0]   out_id,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      err
);

   localparam int LW = $clog2(NREQ);
   localparam int CW = $clog2(NBITS);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT, DELIVER} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WW-1:0]     wcnt_q, wcnt_d;
   logic [LW-1:0]     lane_q, lane_d;
   logic [LW-1:0]     ptr_q, ptr_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic              start_q, start_d;
   logic              err_q, err_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic [NBITS-1:0]  data_q, data_d;
   logic [LW-1:0]     id_q, id_d;
   logic [LW-1:0]     pick;
   logic [LW-1:0]     laneNext;

   // Search starts at ptr and wraps, so the lane just served is considered last.
   always_comb begin
      int idx;
      logic found;
      pick  = ptr_q;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[idx]) begin
            pick  = LW'(idx);
            found = 1'b1;
         end
      end
   end

   assign laneNext = (lane_q == LW'(NREQ - 1)) ? '0 : lane_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      lane_d  = lane_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      start_d = 1'b0;
      err_d   = 1'b0;
      valid_d = valid_q;
      data_d  = data_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               lane_d  = pick;
               grant_d = NREQ'(1) << pick;
               cnt_d   = '0;
               start_d = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(NBITS - 1)) begin
               cnt_d   = '0;
               wcnt_d  = '0;
               grant_d = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (conv_end) begin
               data_d  = conv_data;
               id_d    = lane_q;
               valid_d = 1'b1;
               state_d = DELIVER;
            end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               ptr_d   = laneNext;
               state_d = IDLE;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         DELIVER: begin
            if (out_ready) begin
               valid_d = 1'b0;
               ptr_d   = laneNext;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Async reset drops grant the instant reset_n falls, discarding any word in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         lane_q  <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
         start_q <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         lane_q  <= lane_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         start_q <= start_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
         id_q    <= id_d;
      end
   end

   assign grant      = grant_q;
   assign bit_idx    = cnt_q;
   assign conv_start = start_q;
   assign conv_d     = |(ser_d & grant_q);
   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign out_id     = id_q;
   assign busy       = busy_q;
   assign err        = err_q;

endmodule

// File: tb/tb_s2p_lane_arbiter.sv
// Directed bench for s2p_lane_arbiter with behavioural lane sources, a converter model
// and a scoreboard of expected (lane, word) deliveries.
module tb_s2p_lane_arbiter;

   localparam int NREQ    = 4;
   localparam int NBITS   = 8;
   localparam int TIMEOUT = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  ser_d;
   logic [NREQ-1:0]  grant;
   logic [2:0]       bit_idx;
   logic             conv_start;
   logic             conv_d;
   logic             conv_end;
   logic [NBITS-1:0] conv_data;
   logic             out_valid;
   logic [NBITS-1:0] out_data;
   logic [1:0]       out_id;
   logic             out_ready;
   logic             busy;
   logic             err;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [NBITS-1:0] laneWord [NREQ];
   logic [3:0]       srcCnt [NREQ];
   logic [NBITS-1:0] convSr;
   logic [3:0]       convCnt;
   logic             convActive;
   logic             convEndPend;
   logic             convEnable;

   logic [1:0]       expId[$];
   logic [NBITS-1:0] expData[$];

   s2p_lane_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .ser_d(ser_d), .grant(grant),
      .bit_idx(bit_idx), .conv_start(conv_start), .conv_d(conv_d),
      .conv_end(conv_end), .conv_data(conv_data), .out_valid(out_valid),
      .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Each lane source walks its own word LSB first while it holds grant.
   always @(posedge clk) begin
      for (int i = 0; i < NREQ; i++)
         srcCnt[i] <= grant[i] ? srcCnt[i] + 4'd1 : 4'd0;
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++)
         ser_d[i] = laneWord[i][srcCnt[i][2:0]];
   end

   // Converter model: shifts from conv_start and pulses conv_end one cycle after the last bit.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         convActive  <= 1'b0;
         convCnt     <= 4'd0;
         convEndPend <= 1'b0;
      end else begin
         convEndPend <= 1'b0;
         if (conv_start) begin
            convSr[0]  <= conv_d;
            convCnt    <= 4'd1;
            convActive <= 1'b1;
         end else if (convActive) begin
            convSr[convCnt[2:0]] <= conv_d;
            convCnt <= convCnt + 4'd1;
            if (convCnt == 4'(NBITS - 1)) begin
               convActive  <= 1'b0;
               convEndPend <= 1'b1;
            end
         end
      end
   end

   assign conv_end  = convEndPend & convEnable;
   assign conv_data = convSr;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] reqVal);
      req = reqVal;
   endtask

   task automatic pushExpected(input logic [1:0] id, input logic [NBITS-1:0] data);
      expId.push_back(id);
      expData.push_back(data);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Every accepted handshake must match the oldest expected delivery.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (expId.size() == 0) begin
            checkOutput("unexpected_delivery", 32'(out_valid), 32'd0);
         end else begin
            checkOutput("deliver_id", 32'(out_id), 32'(expId.pop_front()));
            checkOutput("deliver_data", 32'(out_data), 32'(expData.pop_front()));
         end
      end
   end

   initial begin
      logic [NBITS-1:0] w;
      reset_n    = 1'b0;
      out_ready  = 1'b1;
      convEnable = 1'b1;
      applyStimulus('0);
      for (int i = 0; i < NREQ; i++) laneWord[i] = 8'h00;
      tick(2);
      checkOutput("rst_grant", 32'(grant), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_start", 32'(conv_start), 32'd0);
      checkOutput("rst_bitidx", 32'(bit_idx), 32'd0);
      checkOutput("rst_data", 32'(out_data), 32'd0);
      checkOutput("rst_id", 32'(out_id), 32'd0);
      checkOutput("rst_convd", 32'(conv_d), 32'd0);
      reset_n = 1'b1;
      tick(1);

      $display("[TB] single word on lane 2");
      w = 8'hA5;
      laneWord[2] = w;
      applyStimulus(4'b0100);
      pushExpected(2'd2, w);
      tick(1);
      checkOutput("sw_start", 32'(conv_start), 32'd1);
      checkOutput("sw_grant", 32'(grant), 32'b0100);
      checkOutput("sw_bitidx0", 32'(bit_idx), 32'd0);
      checkOutput("sw_convd0", 32'(conv_d), 32'(w[0]));
      checkOutput("sw_busy", 32'(busy), 32'd1);
      applyStimulus('0);
      for (int k = 1; k < NBITS; k++) begin
         tick(1);
         checkOutput("sw_grant_hold", 32'(grant), 32'b0100);
         checkOutput("sw_bitidx", 32'(bit_idx), 32'(k));
         checkOutput("sw_start_low", 32'(conv_start), 32'd0);
         checkOutput("sw_convd", 32'(conv_d), 32'(w[k]));
      end
      tick(1);
      checkOutput("sw_wait_grant", 32'(grant), 32'd0);
      checkOutput("sw_wait_valid", 32'(out_valid), 32'd0);
      tick(1);
      checkOutput("sw_valid", 32'(out_valid), 32'd1);
      checkOutput("sw_data", 32'(out_data), 32'hA5);
      checkOutput("sw_id", 32'(out_id), 32'd2);
      tick(1);
      checkOutput("sw_idle_busy", 32'(busy), 32'd0);
      checkOutput("sw_idle_valid", 32'(out_valid), 32'd0);

      $display("[TB] round robin from fresh reset");
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      laneWord[0] = 8'h11; laneWord[1] = 8'h22; laneWord[2] = 8'h44; laneWord[3] = 8'h88;
      applyStimulus(4'b1111);
      pushExpected(2'd0, 8'h11); pushExpected(2'd1, 8'h22); pushExpected(2'd2, 8'h44);
      pushExpected(2'd3, 8'h88); pushExpected(2'd0, 8'h11);
      tick(1);
      for (int n = 0; n < 5; n++) begin
         checkOutput("rr_grant", 32'(grant), 32'(4'b0001 << (n % 4)));
         checkOutput("rr_start", 32'(conv_start), 32'd1);
         if (n < 4) tick(11);
      end
      applyStimulus('0);
      tick(10);
      checkOutput("rr_idle", 32'(busy), 32'd0);

      $display("[TB] backpressure on lane 1");
      out_ready = 1'b0;
      laneWord[1] = 8'h3C;
      applyStimulus(4'b0010);
      pushExpected(2'd1, 8'h3C);
      tick(1);
      checkOutput("bp_grant", 32'(grant), 32'b0010);
      applyStimulus(4'b0001);
      pushExpected(2'd0, 8'h11);
      tick(9);
      for (int i = 0; i < 20; i++) begin
         checkOutput("bp_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_data", 32'(out_data), 32'h3C);
         checkOutput("bp_id", 32'(out_id), 32'd1);
         checkOutput("bp_nogrant", 32'(grant), 32'd0);
         tick(1);
      end
      out_ready = 1'b1;
      tick(1);
      checkOutput("bp_after_valid", 32'(out_valid), 32'd0);
      checkOutput("bp_after_busy", 32'(busy), 32'd0);
      tick(1);
      checkOutput("bp_next_grant", 32'(grant), 32'b0001);
      applyStimulus('0);
      tick(10);
      checkOutput("bp_done", 32'(busy), 32'd0);

      $display("[TB] converter timeout on lane 3");
      convEnable = 1'b0;
      applyStimulus(4'b1000);
      tick(1);
      checkOutput("to_grant", 32'(grant), 32'b1000);
      applyStimulus('0);
      tick(11);
      checkOutput("to_err_early", 32'(err), 32'd0);
      checkOutput("to_busy_wait", 32'(busy), 32'd1);
      tick(1);
      checkOutput("to_err", 32'(err), 32'd1);
      checkOutput("to_busy", 32'(busy), 32'd0);
      checkOutput("to_novalid", 32'(out_valid), 32'd0);
      convEnable = 1'b1;
      applyStimulus(4'b0011);
      pushExpected(2'd0, 8'h11);
      tick(1);
      checkOutput("to_err_once", 32'(err), 32'd0);
      checkOutput("to_next_grant", 32'(grant), 32'b0001);
      applyStimulus('0);
      tick(10);
      checkOutput("to_done", 32'(busy), 32'd0);

      $display("[TB] lane 1 drops req mid-word");
      laneWord[1] = 8'h5A;
      applyStimulus(4'b0010);
      pushExpected(2'd1, 8'h5A);
      tick(1);
      checkOutput("rd_grant", 32'(grant), 32'b0010);
      for (int k = 2; k <= NBITS; k++) begin
         tick(1);
         if (k == 4) applyStimulus('0);
         checkOutput("rd_grant_hold", 32'(grant), 32'b0010);
      end
      tick(2);
      checkOutput("rd_valid", 32'(out_valid), 32'd1);
      tick(1);
      checkOutput("rd_done", 32'(busy), 32'd0);

      $display("[TB] reset during shift");
      laneWord[2] = 8'hC3;
      applyStimulus(4'b0100);
      tick(1);
      checkOutput("rs_grant", 32'(grant), 32'b0100);
      tick(5);
      checkOutput("rs_bitidx", 32'(bit_idx), 32'd5);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("rs_grant_async", 32'(grant), 32'd0);
      checkOutput("rs_busy_async", 32'(busy), 32'd0);
      applyStimulus('0);
      tick(2);
      reset_n = 1'b1;
      tick(1);
      laneWord[3] = 8'h96;
      applyStimulus(4'b1000);
      pushExpected(2'd3, 8'h96);
      tick(1);
      checkOutput("rs_lane3_grant", 32'(grant), 32'b1000);
      applyStimulus('0);
      tick(10);
      checkOutput("rs_done", 32'(busy), 32'd0);
      tick(1);
      checkOutput("sb_drained", 32'(expId.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
